// File: rtl/atpg_pkg.sv
// Shared types and constants for the ATPG pattern sequencer.
// Pattern word layout is fixed here; the top's width parameters default to these values.
package atpg_pkg;

  localparam int ATPG_PI_W  = 7;
  localparam int ATPG_PO_W  = 4;
  localparam int ATPG_CNT_W = 8;

  localparam logic [ATPG_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ATPG_CNT_W-1:0] NO_FAIL = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } atpg_state_t;

  typedef struct packed {
    logic [ATPG_PI_W-1:0] stim;
    logic [ATPG_PO_W-1:0] exp;
    logic [ATPG_PO_W-1:0] xmask;
    logic                 last;
  } atpg_pat_t;

endpackage

// File: rtl/atpg_pat_fifo.sv
// Synchronous pattern FIFO, DEPTH entries, read data visible combinationally at the head.
// Push ignored when full, pop ignored when empty; push and pop in one cycle both take effect.
module atpg_pat_fifo
  import atpg_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  atpg_pat_t push_dat,
  input  logic      pop,
  output atpg_pat_t pop_dat,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        push_en;
  logic        pop_en;
  atpg_pat_t   mem_q [DEPTH];

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign pop_dat = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_en) wptr_d = wptr_q + (AW+1)'(1);
    if (pop_en)  rptr_d = rptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wptr_q[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/atpg_pattern_sequencer.sv
// Buffers ATPG patterns, drives them onto the CUT, samples after a settle window and scores responses.
// Optional MISR signature over masked CUT outputs is built only when ATPG_MISR_EN is defined.
module atpg_pattern_sequencer
  import atpg_pkg::*;
#(
  parameter int PI_W   = ATPG_PI_W,
  parameter int PO_W   = ATPG_PO_W,
  parameter int DEPTH  = 8,
  parameter int SETTLE = 2,
  parameter int CNT_W  = ATPG_CNT_W
`ifdef ATPG_MISR_EN
  , parameter logic [ATPG_PO_W-1:0] MISR_POLY = 4'b1001
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic [PI_W-1:0]  pat_stim,
  input  logic [PO_W-1:0]  pat_exp,
  input  logic [PO_W-1:0]  pat_xmask,
  input  logic             pat_last,
  output logic [PI_W-1:0]  cut_pi,
  input  logic [PO_W-1:0]  cut_po,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [CNT_W-1:0] pat_cnt
`ifdef ATPG_MISR_EN
  , output logic [PO_W-1:0] signature
`endif
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_RLD = SW'((SETTLE > 0) ? SETTLE - 1 : 0);

  atpg_state_t      state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [PI_W-1:0]  cut_pi_q, cut_pi_d;
  logic [PO_W-1:0]  exp_q, exp_d;
  logic [PO_W-1:0]  xmask_q, xmask_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0] first_fail_q, first_fail_d;
  logic [CNT_W-1:0] pat_cnt_q, pat_cnt_d;
  logic             pass_q, pass_d;
  logic             mism;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  atpg_pat_t        fifo_dat;
  atpg_pat_t        push_dat;
`ifdef ATPG_MISR_EN
  logic [PO_W-1:0]  sig_q, sig_d;
`endif

  assign push_dat = '{stim: pat_stim, exp: pat_exp, xmask: pat_xmask, last: pat_last};

  atpg_pat_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (pat_valid),
    .push_dat(push_dat),
    .pop     (fifo_pop),
    .pop_dat (fifo_dat),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign mism = |((cut_po ^ exp_q) & ~xmask_q);

  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    cut_pi_d     = cut_pi_q;
    exp_d        = exp_q;
    xmask_d      = xmask_q;
    last_d       = last_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;
    pat_cnt_d    = pat_cnt_q;
    pass_d       = pass_q;
    fifo_pop     = 1'b0;
`ifdef ATPG_MISR_EN
    sig_d        = sig_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          fail_cnt_d   = '0;
          pat_cnt_d    = '0;
          first_fail_d = NO_FAIL;
          pass_d       = 1'b0;
`ifdef ATPG_MISR_EN
          sig_d        = '0;
`endif
          state_d      = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cut_pi_d = fifo_dat.stim;
          exp_d    = fifo_dat.exp;
          xmask_d  = fifo_dat.xmask;
          last_d   = fifo_dat.last;
          settle_d = SETTLE_RLD;
          state_d  = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) state_d = ST_CAPTURE;
        else                settle_d = settle_q - SW'(1);
      end
      ST_CAPTURE: begin
        if (mism) begin
          if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + CNT_W'(1);
          // A zero count before this increment means this is the session's first miss.
          if (fail_cnt_q == '0) first_fail_d = pat_cnt_q;
        end
        pat_cnt_d = pat_cnt_q + CNT_W'(1);
`ifdef ATPG_MISR_EN
        sig_d = {sig_q[PO_W-2:0], 1'b0} ^ (sig_q[PO_W-1] ? MISR_POLY : '0) ^ (cut_po & ~xmask_q);
`endif
        state_d = last_q ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        pass_d  = (fail_cnt_q == '0);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      settle_q     <= '0;
      cut_pi_q     <= '0;
      exp_q        <= '0;
      xmask_q      <= '0;
      last_q       <= 1'b0;
      fail_cnt_q   <= '0;
      first_fail_q <= NO_FAIL;
      pat_cnt_q    <= '0;
      pass_q       <= 1'b0;
`ifdef ATPG_MISR_EN
      sig_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      cut_pi_q     <= cut_pi_d;
      exp_q        <= exp_d;
      xmask_q      <= xmask_d;
      last_q       <= last_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
      pat_cnt_q    <= pat_cnt_d;
      pass_q       <= pass_d;
`ifdef ATPG_MISR_EN
      sig_q        <= sig_d;
`endif
    end
  end

  assign pat_ready      = !fifo_full;
  assign cut_pi         = cut_pi_q;
  assign busy           = (state_q == ST_FETCH) || (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
  assign done           = (state_q == ST_DONE);
  assign pass           = pass_q;
  assign fail_cnt       = fail_cnt_q;
  assign first_fail_idx = first_fail_q;
  assign pat_cnt        = pat_cnt_q;
`ifdef ATPG_MISR_EN
  assign signature      = sig_q;
`endif

endmodule

// File: tb/tb_atpg_pattern_sequencer.sv
// Directed-plus-random bench for atpg_pattern_sequencer with a behavioural 7-in/4-out CUT.
// Session outcomes are predicted from the pattern list alone; ATPG_MISR_EN enables signature checks.
module tb_atpg_pattern_sequencer;

  localparam int S = 2;
  localparam int PER = S + 2;

  typedef struct {
    logic [6:0] stim;
    logic [3:0] exp;
    logic [3:0] xm;
    logic       last;
  } tp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic       pat_valid;
  logic       pat_ready;
  logic [6:0] pat_stim;
  logic [3:0] pat_exp;
  logic [3:0] pat_xmask;
  logic       pat_last;
  logic [6:0] cut_pi;
  logic [3:0] cut_po;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] fail_cnt;
  logic [7:0] first_fail_idx;
  logic [7:0] pat_cnt;
`ifdef ATPG_MISR_EN
  logic [3:0] signature;
`endif

  int vectors = 0;
  int miscompares = 0;
  tp_t q[$];
  logic [6:0] busy_log[$];

  atpg_pattern_sequencer #(.DEPTH(8), .SETTLE(S)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pat_valid     (pat_valid),
    .pat_ready     (pat_ready),
    .pat_stim      (pat_stim),
    .pat_exp       (pat_exp),
    .pat_xmask     (pat_xmask),
    .pat_last      (pat_last),
    .cut_pi        (cut_pi),
    .cut_po        (cut_po),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .fail_cnt      (fail_cnt),
    .first_fail_idx(first_fail_idx),
`ifdef ATPG_MISR_EN
    .pat_cnt       (pat_cnt),
    .signature     (signature)
`else
    .pat_cnt       (pat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural CUT: arbitrary fixed 7-in/4-out logic function.
  function automatic logic [3:0] cut_f(input logic [6:0] x);
    return {^x, (x[0] & x[1]) | x[2], ~(x[3] | x[4]) ^ x[5], (x[6] & x[2]) ^ x[1]};
  endfunction

  always_comb cut_po = cut_f(cut_pi);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic tp_t mk(input logic [6:0] stim, input logic [3:0] flip,
                             input logic [3:0] xm, input logic last);
    tp_t p;
    p.stim = stim;
    p.exp  = cut_f(stim) ^ flip;
    p.xm   = xm;
    p.last = last;
    return p;
  endfunction

  task automatic push(input tp_t p);
    int w;
    @(negedge clk);
    pat_valid = 1'b1;
    pat_stim  = p.stim;
    pat_exp   = p.exp;
    pat_xmask = p.xm;
    pat_last  = p.last;
    w = 0;
    while (!pat_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) check("push_timeout", 32'(w), 32'(0));
    @(posedge clk);
    #1;
    pat_valid = 1'b0;
  endtask

  // Runs one session over the n patterns in q (already pushed or being pushed).
  task automatic run_session(input string tag, input int n, input int mid_start);
    int cyc;
    bit seen;
    int fails;
    logic [7:0] first;
    logic [3:0] sig;
    logic [3:0] po;
    busy_log.delete();
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    seen = 0;
    while (cyc < 3000 && !seen) begin
      @(negedge clk);
      start = 1'b0;
      if (mid_start > 0 && busy_log.size() == mid_start) start = 1'b1;
      if (busy) busy_log.push_back(cut_pi);
      if (done) seen = 1;
      cyc++;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'(1));
    check({tag, "_busy_cycles"}, 32'(busy_log.size()), 32'(n * PER));
    for (int i = 0; i < n; i++) begin
      if (i * PER + S + 1 < busy_log.size())
        check({tag, "_applied_stim"}, 32'(busy_log[i * PER + S + 1]), 32'(q[i].stim));
    end
    fails = 0;
    first = 8'hFF;
    sig = 4'h0;
    for (int i = 0; i < n; i++) begin
      po = cut_f(q[i].stim);
      if (((po ^ q[i].exp) & ~q[i].xm) != 4'h0) begin
        if (fails == 0) first = 8'(i);
        if (fails < 255) fails++;
      end
      sig = {sig[2:0], 1'b0} ^ (sig[3] ? 4'b1001 : 4'b0000) ^ (po & ~q[i].xm);
    end
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'(0));
    check({tag, "_pass"}, 32'(pass), 32'(fails == 0));
    check({tag, "_fail_cnt"}, 32'(fail_cnt), 32'(fails));
    check({tag, "_first_fail_idx"}, 32'(first_fail_idx), 32'(first));
    check({tag, "_pat_cnt"}, 32'(pat_cnt), 32'(n % 256));
`ifdef ATPG_MISR_EN
    check({tag, "_signature"}, 32'(signature), 32'(sig));
`else
    if (sig == 4'hF) sig = 4'h0;
`endif
  endtask

  initial begin
    int n;
    int cyc;
    bit seen;
    logic [3:0] b;
    rst = 1'b1;
    start = 1'b0;
    pat_valid = 1'b0;
    pat_stim = '0;
    pat_exp = '0;
    pat_xmask = '0;
    pat_last = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_pass", 32'(pass), 32'(0));
    check("rst_cut_pi", 32'(cut_pi), 32'(0));
    check("rst_fail_cnt", 32'(fail_cnt), 32'(0));
    check("rst_pat_cnt", 32'(pat_cnt), 32'(0));
    check("rst_first_fail", 32'(first_fail_idx), 32'hFF);
    check("rst_ready", 32'(pat_ready), 32'(1));
`ifdef ATPG_MISR_EN
    check("rst_signature", 32'(signature), 32'(0));
`endif
    rst = 1'b0;

    // Four correct patterns, random don't-care masks.
    q.delete();
    for (int i = 0; i < 4; i++)
      q.push_back(mk(7'($urandom), 4'h0, 4'($urandom), i == 3));
    foreach (q[i]) push(q[i]);
    run_session("all_good", 4, 0);

    // Wrong expectations on patterns 1 and 3.
    q.delete();
    for (int i = 0; i < 4; i++) begin
      b = 4'(1 << $urandom_range(0, 3));
      q.push_back(mk(7'($urandom), (i == 1 || i == 3) ? b : 4'h0, 4'h0, i == 3));
    end
    foreach (q[i]) push(q[i]);
    run_session("two_fails", 4, 0);

    // Mismatch only on a masked bit.
    q.delete();
    for (int i = 0; i < 4; i++) begin
      b = 4'(1 << $urandom_range(0, 3));
      q.push_back(mk(7'($urandom), (i == 2) ? b : 4'h0, (i == 2) ? b : 4'h0, i == 3));
    end
    foreach (q[i]) push(q[i]);
    run_session("masked", 4, 0);

    // Nine patterns into an eight-deep FIFO; the ninth waits for the first pop.
    q.delete();
    for (int i = 0; i < 9; i++)
      q.push_back(mk(7'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                     4'h0, i == 8));
    for (int i = 0; i < 8; i++) push(q[i]);
    @(negedge clk);
    check("full_ready_low", 32'(pat_ready), 32'(0));
    fork
      push(q[8]);
      run_session("nine", 9, 0);
    join

    // Reset in the first settle cycle of the second pattern.
    q.delete();
    for (int i = 0; i < 4; i++)
      q.push_back(mk(7'($urandom), 4'h1, 4'h0, i == 3));
    foreach (q[i]) push(q[i]);
    busy_log.delete();
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    while (cyc < 200 && busy_log.size() < S + 4) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_log.push_back(cut_pi);
      cyc++;
    end
    check("rst_mid_reached", 32'(busy_log.size()), 32'(S + 4));
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", 32'(busy), 32'(0));
    check("rst_mid_done", 32'(done), 32'(0));
    check("rst_mid_cut_pi", 32'(cut_pi), 32'(0));
    check("rst_mid_fail_cnt", 32'(fail_cnt), 32'(0));
    check("rst_mid_pat_cnt", 32'(pat_cnt), 32'(0));
    check("rst_mid_first_fail", 32'(first_fail_idx), 32'hFF);
    check("rst_mid_pass", 32'(pass), 32'(0));
    check("rst_mid_ready", 32'(pat_ready), 32'(1));
    rst = 1'b0;
    // An emptied FIFO leaves a fresh session waiting with nothing applied.
    start = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
      if (done) seen = 1;
    end
    check("flushed_wait_busy", 32'(busy), 32'(1));
    check("flushed_wait_pat_cnt", 32'(pat_cnt), 32'(0));
    check("flushed_wait_cut_pi", 32'(cut_pi), 32'(0));
    check("flushed_no_done", 32'(seen), 32'(0));
    q.delete();
    q.push_back(mk(7'h5A, 4'h0, 4'h0, 1'b1));
    push(q[0]);
    cyc = 0;
    while (cyc < 200 && !done) begin
      @(negedge clk);
      cyc++;
    end
    check("flushed_done", 32'(done), 32'(1));
    @(negedge clk);
    check("flushed_pat_cnt", 32'(pat_cnt), 32'(1));
    check("flushed_pass", 32'(pass), 32'(1));

    // Fixed set for the signature, with start pulsed mid-session.
    q.delete();
    q.push_back(mk(7'h00, 4'h0, 4'h0, 1'b0));
    q.push_back(mk(7'h7F, 4'h2, 4'h3, 1'b0));
    q.push_back(mk(7'h2A, 4'h4, 4'h0, 1'b0));
    q.push_back(mk(7'h55, 4'h0, 4'h8, 1'b1));
    foreach (q[i]) push(q[i]);
    run_session("fixed_mid_start", 4, 5);

    // Random sessions.
    for (int s = 0; s < 3; s++) begin
      n = $urandom_range(1, 8);
      q.delete();
      for (int i = 0; i < n; i++)
        q.push_back(mk(7'($urandom), ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
                       4'($urandom) & 4'($urandom), i == n - 1));
      foreach (q[i]) push(q[i]);
      run_session("random", n, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
